// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider (quotient + remainder, RISC-V DIV/DIVU/REM/REMU semantics).
// Signed operation is built only when SIGNED_DIV_EN is defined; otherwise everything is unsigned.
module sequential_divider #(
    parameter int l = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Signed,
    input  logic [l-1:0] X,
    input  logic [l-1:0] Y,
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Q,
    output logic [l-1:0] R,
    output logic         DivZero,
    output logic         Overflow
);

    localparam int CW = $clog2(l + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic [l-1:0]  rem, dvd, dvs;
    logic [l:0]    sh, diff;
    logic [l-1:0]  rem_nx, dvd_nx;
    logic [l-1:0]  xa, ya;
    logic          ovf_case;

`ifdef SIGNED_DIV_EN
    logic qneg, rneg, ovf;
    logic xneg, yneg;

    assign xneg     = Signed & X[l-1];
    assign yneg     = Signed & Y[l-1];
    assign xa       = xneg ? -X : X;
    assign ya       = yneg ? -Y : Y;
    assign ovf_case = Signed && (X == {1'b1, {(l-1){1'b0}}}) && (Y == '1);
    assign Overflow = ovf;
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign xa            = X;
    assign ya            = Y;
    assign ovf_case      = 1'b0;
    assign Overflow      = 1'b0;
`endif

    // One restoring step: diff[l] is the borrow of the l+1 bit trial subtraction.
    assign sh     = {rem, dvd[l-1]};
    assign diff   = sh - {1'b0, dvs};
    assign rem_nx = diff[l] ? sh[l-1:0] : diff[l-1:0];
    assign dvd_nx = {dvd[l-2:0], ~diff[l]};

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (Start) nstate = ((Y == '0) || ovf_case) ? DONE : CALC;
            CALC: if (cnt == CW'(1)) nstate = DONE;
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            Q       <= '0;
            R       <= '0;
            DivZero <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (Start) begin
                    DivZero <= 1'b0;
`ifdef SIGNED_DIV_EN
                    ovf     <= 1'b0;
`endif
                    if (Y == '0) begin
                        Q       <= '1;
                        R       <= X;
                        DivZero <= 1'b1;
                    end else if (ovf_case) begin
                        Q <= X;
                        R <= '0;
`ifdef SIGNED_DIV_EN
                        ovf <= 1'b1;
`endif
                    end else begin
                        dvd <= xa;
                        dvs <= ya;
                        rem <= '0;
                        cnt <= CW'(l);
`ifdef SIGNED_DIV_EN
                        qneg <= xneg ^ yneg;
                        rneg <= xneg;
`endif
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt - CW'(1);
                    // Results land on the last step so they are valid while Done is high.
                    if (cnt == CW'(1)) begin
`ifdef SIGNED_DIV_EN
                        Q <= qneg ? -dvd_nx : dvd_nx;
                        R <= rneg ? -rem_nx : rem_nx;
`else
                        Q <= dvd_nx;
                        R <= rem_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: driver pushes reference results, monitor checks on Done.
module tb_sequential_divider;

`ifdef SIGNED_DIV_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        Clk, Reset, Start, Signed;
    logic [15:0] X, Y, Q, R;
    logic        Busy, Done, DivZero, Overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          n;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    sequential_divider #(.l(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
        .X(X), .Y(Y), .Busy(Busy), .Done(Done), .Q(Q), .R(R),
        .DivZero(DivZero), .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the architectural special cases.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t e;
        int   xs, ys;
        e = '0;
        if (y == 16'd0) begin
            e.q = 16'hffff; e.r = x; e.dz = 1'b1; e.lat = 1;
        end else if (s && SB && x == 16'h8000 && y == 16'hffff) begin
            e.q = x; e.r = 16'd0; e.ov = 1'b1; e.lat = 1;
        end else if (s && SB) begin
            xs = $signed(x);
            ys = $signed(y);
            e.q = 16'(xs / ys);
            e.r = 16'(xs % ys);
            e.lat = 17;
        end else begin
            e.q = x / y;
            e.r = x % y;
            e.lat = 17;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 required no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", 32'(Q), 32'(e.q));
                chk("r", 32'(R), 32'(e.r));
                chk("divzero", 32'(DivZero), 32'(e.dz));
                chk("overflow", 32'(Overflow), 32'(e.ov));
                chk("latency", 32'(cyc - e.n + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got Busy=1 required 0 within 100 cycles");
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t e;
        X = x; Y = y; Signed = s; Start = 1'b1;
        @(posedge Clk);
        #1;
        e = model(x, y, s);
        e.n = cyc;
        sb.push_back(e);
        last_exp = e;
        Start = 1'b0;
        X = 16'($urandom); Y = 16'($urandom); Signed = 1'($urandom);
        @(negedge Clk);
        chk("busy_after_start", 32'(Busy), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s);
        wait_idle();
        do_op(x, y, s);
        wait_idle();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; X = '0; Y = '0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_flags", 32'({DivZero, Overflow}), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run_op(16'd100, 16'd7, 1'b0);
        repeat (2) @(negedge Clk);
        chk("hold_q", 32'(Q), 32'(last_exp.q));
        chk("hold_r", 32'(R), 32'(last_exp.r));

        run_op(16'hfff9, 16'h0002, 1'b1);
        run_op(16'h0007, 16'hfffe, 1'b1);
        run_op(16'h1234, 16'h0000, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b1);
        run_op(16'h8000, 16'hffff, 1'b1);
        run_op(16'h8000, 16'hffff, 1'b0);
        run_op(16'hffff, 16'h0001, 1'b0);
        run_op(16'h0000, 16'h0005, 1'b1);

        // Start pulses while busy must be ignored.
        wait_idle();
        do_op(16'd100, 16'd7, 1'b0);
        X = 16'd50; Y = 16'd5; Signed = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_idle();

        // Back-to-back with only the mandatory idle cycle between ops.
        wait_idle();
        do_op(16'd1000, 16'd10, 1'b0);
        wait_idle();
        do_op(16'd77, 16'd0, 1'b0);
        wait_idle();
        do_op(16'd65535, 16'd255, 1'b0);
        wait_idle();

        // Asynchronous reset mid-operation: outputs clear before any clock edge.
        do_op(16'd100, 16'd7, 1'b0);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_q", 32'(Q), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_op(16'd9, 16'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] rx, ry;
            rx = 16'($urandom);
            ry = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ry = 16'd0;
                1: begin rx = 16'h8000; ry = 16'hffff; end
                2: ry = 16'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(rx, ry, 1'($urandom));
        end

        repeat (3) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Multi-cycle restoring divider for the i16 ALU; subtract-direction counterpart to the combinational adder with Overflow/Carry flags.
- Computes quotient and remainder by one trial subtraction per bit.
- Supports signed and unsigned operation with RISC-V DIV/DIVU/REM/REMU semantics.
- Sits beside the adder in the ALU and is driven by the execute stage through a Start/Busy/Done handshake.

Parameters:
l, 16, operand/result width in bits (l >= 2)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with Start
X  input  l  dividend; sampled with Start
Y  input  l  divisor; sampled with Start
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse; Q/R/flags valid from this cycle on
Q  output  l  quotient, registered
R  output  l  remainder, registered
DivZero  output  1  divisor was zero, registered
Overflow  output  1  signed -2^(l-1) / -1 case, registered

Behaviour:
- Reset (async, any state): state=IDLE; Busy, Done, Q, R, DivZero and Overflow all 0; iteration counter 0.
- States: IDLE, CALC, DONE. Busy=1 in CALC and DONE.
- IDLE:
  - Start=1 at edge N latches X, Y and Signed, and clears DivZero/Overflow.
  - Y==0: go to DONE; Q=all ones, R=X, DivZero=1.
  - Signed and X==1<<(l-1) and Y==all ones: go to DONE; Q=X, R=0, Overflow=1.
  - Otherwise: take magnitudes (two's-complement negate negative operands when Signed), record quotient sign = sign(X) xor sign(Y) and remainder sign = sign(X), load counter=l, go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial = rem - divisor, computed l+1 bits wide; the borrow decides the quotient bit.
  - No borrow: rem = trial, quotient bit = 1. Borrow: rem unchanged, quotient bit = 0.
  - Decrement counter; when it reaches 0, go to DONE.
- DONE: held one cycle; Done=1. Q/R carry sign-corrected results (negate quotient / remainder per the recorded signs); zero results are never negated. Next state IDLE.
- Latency: normal ops assert Done at cycle N+l+1 (17 for l=16); special cases assert Done at cycle N+1.
- Q, R, DivZero and Overflow hold their values after Done until the next accepted Start clears the flags. Q/R update only in the DONE cycle.
- Start while Busy (CALC or DONE) is ignored and not queued.
- Start asserted in the cycle after Done (IDLE) is accepted; back-to-back ops run with one idle cycle between them.
- Operand changes on X/Y/Signed after acceptance have no effect.
- Reset mid-CALC aborts immediately; no Done pulse is produced.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined: Signed is honoured as above.
- Undefined: Signed is ignored and all operations are unsigned; no negation logic is built; Overflow is tied to 0 but the port is kept; divide-by-zero behaviour is unchanged.

Test Plan:
- Unsigned X=100, Y=7, Start pulse -> Busy=1 next cycle; Done at N+17 with Q=14, R=2, DivZero=0, Overflow=0.
- Signed X=0xFFF9 (-7), Y=0x0002 -> Q=0xFFFD (-3), R=0xFFFF (-1).
- Signed X=0x0007, Y=0xFFFE (-2) -> Q=0xFFFD, R=0x0001.
- Divide by zero X=0x1234, Y=0 (either mode) -> Done at N+1; Q=0xFFFF, R=0x1234, DivZero=1.
- Signed X=0x8000, Y=0xFFFF -> Done at N+1; Q=0x8000, R=0, Overflow=1. Same operands unsigned -> Q=0, R=0x8000, Overflow=0, 17-cycle latency.
- Hazards:
  - Start 100/7, re-pulse Start with 50/5 during CALC -> result still Q=14, R=2.
  - Reset asserted mid-CALC -> all outputs 0 without waiting for a clock edge; no Done pulse.
  - After Reset deasserts, Start 9/3 -> Q=3, R=0.
